// File: rtl/fp_pkg.sv
// fp_pkg -- shared constants and FSM state type for the int_to_fp converter.
//   INT_W    : integer operand width
//   EXP_W    : IEEE754 single exponent width
//   FRAC_W   : IEEE754 single stored fraction width
//   EXP_BIAS : exponent bias
//   EXP_TOP  : biased exponent of an operand whose MSB sits in bit INT_W-1
// Build option INT_TO_FP_SIGNED_EN is consumed by int_to_fp, not here.
package fp_pkg;

  localparam int INT_W    = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int CNT_W    = 5;

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne -- combinational round-to-nearest-even packer.
// Takes a normalised magnitude (bit INT_W-1 set) plus the number of left
// shifts applied, and produces the packed single-precision word.
// Ports:
//   sign    : sign bit to place in the result
//   mag     : normalised magnitude, MSB = implicit leading one
//   count   : leading-zero count removed during normalisation
//   result  : {sign, exponent, fraction} after rounding
//   inexact : high when any discarded bit was nonzero
module fp_round_rne
  import fp_pkg::*;
(
  input  logic             sign,
  input  logic [INT_W-1:0] mag,
  input  logic [CNT_W-1:0] count,
  output logic [INT_W-1:0] result,
  output logic             inexact
);

  localparam int FRAC_LO = INT_W - 1 - FRAC_W;  // lowest kept bit
  localparam int GUARD   = FRAC_LO - 1;

  // Returns {inexact, packed result}.
  function automatic logic [INT_W:0] round_rne(
    input logic             s,
    input logic [INT_W-1:0] m,
    input logic [CNT_W-1:0] c
  );
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   frac;
    logic              guard;
    logic              sticky;
    logic              up;
    exp    = EXP_TOP - EXP_W'(c);
    guard  = m[GUARD];
    sticky = |m[GUARD-1:0];
    up     = guard & (sticky | m[FRAC_LO]);
    frac   = {1'b0, m[INT_W-2:FRAC_LO]} + (FRAC_W+1)'(up);
    // Fraction wrapped to zero: the mantissa became 2.0, bump the exponent.
    if (frac[FRAC_W]) exp = exp + EXP_W'(1);
    return {guard | sticky, s, exp, frac[FRAC_W-1:0]};
  endfunction

  assign {inexact, result} = round_rne(sign, mag, count);

endmodule

// File: rtl/int_to_fp.sv
// int_to_fp -- multi-cycle 32-bit integer to IEEE754 single converter.
// Sequence: IDLE -> ABS -> NORM (one left shift per cycle) -> ROUND -> DONE.
// Build option: define INT_TO_FP_SIGNED_EN to treat num as two's complement;
// otherwise num is unsigned.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   start   : conversion request, honoured only while ready
//   num     : integer operand, captured on the accepting edge
//   ready   : high in IDLE
//   done    : one-cycle pulse when result/inexact are valid
//   result  : packed single-precision value, held until the next DONE
//   inexact : rounding discarded nonzero bits
module int_to_fp
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [INT_W-1:0] num,
  output logic             ready,
  output logic             done,
  output logic [INT_W-1:0] result,
  output logic             inexact
);

  state_t           state;
  state_t           state_nxt;
  logic [INT_W-1:0] num_r;
  logic [INT_W-1:0] mag;
  logic             sign;
  logic [CNT_W-1:0] count;
  logic             abs_sign;
  logic [INT_W-1:0] abs_mag;
  logic [INT_W-1:0] rnd_result;
  logic             rnd_inexact;

`ifdef INT_TO_FP_SIGNED_EN
  // Negation wraps 32'h80000000 onto itself, which is exactly 2^31 unsigned.
  assign abs_sign = num_r[INT_W-1];
  assign abs_mag  = abs_sign ? (INT_W'(0) - num_r) : num_r;
`else
  assign abs_sign = 1'b0;
  assign abs_mag  = num_r;
`endif

  fp_round_rne u_round (
    .sign    (sign),
    .mag     (mag),
    .count   (count),
    .result  (rnd_result),
    .inexact (rnd_inexact)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ABS;
      ABS:     state_nxt = (abs_mag == '0) ? DONE : NORM;
      NORM:    if (mag[INT_W-1]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Operand / working magnitude: no reset needed, always rewritten before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) num_r <= num;
      ABS: begin
        sign <= abs_sign;
        mag  <= abs_mag;
      end
      NORM: if (!mag[INT_W-1]) mag <= mag << 1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      result  <= '0;
      inexact <= 1'b0;
    end else begin
      case (state)
        ABS: begin
          count <= '0;
          if (abs_mag == '0) begin
            result  <= '0;
            inexact <= 1'b0;
          end
        end
        NORM: if (!mag[INT_W-1]) count <= count + CNT_W'(1);
        ROUND: begin
          result  <= rnd_result;
          inexact <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule
